// File: rtl/bp_me_wormhole_mem_responder_pkg.sv
// Shared types for the wormhole memory responder and the matching command sender.
//   mem_op_e : header opcode (read/write)
//   state_e  : responder control states
//   hdr_width / link_width : derived widths of a packet header and a ready_and link
package bp_me_wormhole_mem_responder_pkg;

    typedef enum logic {
        e_mem_rd = 1'b0,
        e_mem_wr = 1'b1
    } mem_op_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_REQ,
        RD_WAIT,
        RESP_HDR,
        RESP_DATA
    } state_e;

    // Header is {addr, count, opcode, src, len, dst}, dst in the LSBs.
    function automatic int hdr_width(input int cord_w, input int len_w,
                                     input int count_w, input int addr_w);
        return 2 * cord_w + len_w + 1 + count_w + addr_w;
    endfunction

    // A ready_and link is {v, ready_and_rev, data}.
    function automatic int link_width(input int flit_w);
        return flit_w + 2;
    endfunction

endpackage

// File: rtl/bp_me_wormhole_mem_responder_if.sv
// Valid/ready_and flit channel used between the responder control and its
// response transmitter.
//   v, data   : flit offered by the master
//   ready_and : slave accepts the flit when high together with v
interface bp_me_wormhole_mem_responder_if #(
    parameter int flit_width_p = 64
);
    logic                    v;
    logic [flit_width_p-1:0] data;
    logic                    ready_and;

    modport master (output v, output data, input  ready_and);
    modport slave  (input  v, input  data, output ready_and);
endinterface

// File: rtl/bp_me_wormhole_resp_tx.sv
// Response transmitter: selects header or data flit onto the response channel.
//   hdr_v_i/hdr_i   : header flit request
//   data_v_i/data_i : data flit request
//   link            : outgoing channel (master side)
//   yumi_o          : flit accepted this cycle
// The caller keeps its request asserted until yumi_o, so valid and data hold
// steady while the network is not ready.
module bp_me_wormhole_resp_tx #(
    parameter int flit_width_p = 64
) (
    input  logic                    hdr_v_i,
    input  logic [flit_width_p-1:0] hdr_i,
    input  logic                    data_v_i,
    input  logic [flit_width_p-1:0] data_i,
    bp_me_wormhole_mem_responder_if.master link,
    output logic                    yumi_o
);
    assign link.v    = hdr_v_i | data_v_i;
    assign link.data = hdr_v_i  ? hdr_i
                     : data_v_i ? data_i
                     : '0;
    assign yumi_o    = link.v & link.ready_and;
endmodule

// File: rtl/bp_me_wormhole_mem_responder.sv
// Wormhole memory responder: accepts read/write command packets from the
// network, performs word accesses on a simple valid/ready memory port and
// returns a response header (plus read data) to the requester.
//   clk_i, reset_n_i         : clock, asynchronous active-low reset
//   my_cord_i                : own coordinate, placed in the src field of responses
//   cmd_link_i / cmd_link_o  : command {v, data} in, ready_and_rev out
//   resp_link_o / resp_link_i: response {v, data} out, ready_and_rev in
//   mem_*                    : memory request port and in-order read return
module bp_me_wormhole_mem_responder
    import bp_me_wormhole_mem_responder_pkg::*;
#(
    parameter int flit_width_p  = 64,
    parameter int cord_width_p  = 7,
    parameter int len_width_p   = 3,
    parameter int count_width_p = 2,
    parameter int addr_width_p  = 32,
    localparam int link_width_lp = link_width(flit_width_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [cord_width_p-1:0]  my_cord_i,
    input  logic [link_width_lp-1:0] cmd_link_i,
    output logic [link_width_lp-1:0] cmd_link_o,
    output logic [link_width_lp-1:0] resp_link_o,
    input  logic [link_width_lp-1:0] resp_link_i,
    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [addr_width_p-1:0]  mem_addr_o,
    output logic [flit_width_p-1:0]  mem_data_o,
    input  logic                     mem_ready_i,
    input  logic                     mem_data_v_i,
    input  logic [flit_width_p-1:0]  mem_data_i
);
    localparam int DST_LSB  = 0;
    localparam int LEN_LSB  = cord_width_p;
    localparam int SRC_LSB  = cord_width_p + len_width_p;
    localparam int OP_LSB   = 2 * cord_width_p + len_width_p;
    localparam int CNT_LSB  = OP_LSB + 1;
    localparam int ADDR_LSB = CNT_LSB + count_width_p;

    if (hdr_width(cord_width_p, len_width_p, count_width_p, addr_width_p) > flit_width_p
        || ((1 << len_width_p) - 1) < (1 << count_width_p)) begin : g_bad_params
        $error("bp_me_wormhole_mem_responder: header does not fit flit or len too narrow for count");
    end

    // Command link fields
    logic                    cmd_v;
    logic [flit_width_p-1:0] cmd_flit;
    assign cmd_v    = cmd_link_i[flit_width_p+1];
    assign cmd_flit = cmd_link_i[flit_width_p-1:0];

    // Control state
    state_e                   state_q, state_d;
    logic [count_width_p-1:0] k_q, k_d;
    logic                     live_q;   // low until the first edge after reset release

    // Latched header and read data (no reset needed; written before use)
    mem_op_e                  op_q;
    logic [count_width_p-1:0] cnt_q;
    logic [addr_width_p-1:0]  addr_q;
    logic [cord_width_p-1:0]  src_q;
    logic [flit_width_p-1:0]  data_q;

    logic cmd_ready, hdr_v, data_v, latch_hdr, cap_data, resp_yumi;
    logic [flit_width_p-1:0] resp_hdr;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            live_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (latch_hdr) begin
            op_q   <= mem_op_e'(cmd_flit[OP_LSB]);
            cnt_q  <= cmd_flit[CNT_LSB +: count_width_p];
            addr_q <= cmd_flit[ADDR_LSB +: addr_width_p];
            src_q  <= cmd_flit[SRC_LSB +: cord_width_p];
        end
        if (cap_data) begin
            data_q <= mem_data_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cmd_ready  = 1'b0;
        mem_v_o    = 1'b0;
        mem_w_o    = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        hdr_v      = 1'b0;
        data_v     = 1'b0;
        latch_hdr  = 1'b0;
        cap_data   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = live_q;
                if (cmd_v && live_q) begin
                    latch_hdr = 1'b1;
                    k_d       = '0;
                    state_d   = (cmd_flit[OP_LSB] == e_mem_wr) ? WR_DATA : RESP_HDR;
                end
            end
            WR_DATA: begin
                // Write flits flow straight through to memory; the burst length
                // comes from count, the incoming len field is not consulted.
                cmd_ready  = mem_ready_i;
                mem_v_o    = cmd_v;
                mem_w_o    = 1'b1;
                mem_addr_o = addr_q + addr_width_p'(k_q);
                mem_data_o = cmd_flit;
                if (cmd_v && mem_ready_i) begin
                    k_d = k_q + 1'b1;
                    if (k_q == cnt_q) begin
                        state_d = RESP_HDR;
                    end
                end
            end
            RESP_HDR: begin
                hdr_v = 1'b1;
                if (resp_yumi) begin
                    k_d     = '0;
                    state_d = (op_q == e_mem_wr) ? IDLE : RD_REQ;
                end
            end
            RD_REQ: begin
                mem_v_o    = 1'b1;
                mem_addr_o = addr_q + addr_width_p'(k_q);
                if (mem_ready_i) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_data_v_i) begin
                    cap_data = 1'b1;
                    state_d  = RESP_DATA;
                end
            end
            RESP_DATA: begin
                data_v = 1'b1;
                if (resp_yumi) begin
                    if (k_q == cnt_q) begin
                        k_d     = '0;
                        state_d = IDLE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response header: returned to the requester, len counts the data flits
    // that follow (none for a write ack).
    always_comb begin
        resp_hdr = '0;
        resp_hdr[DST_LSB +: cord_width_p]   = src_q;
        resp_hdr[LEN_LSB +: len_width_p]    = (op_q == e_mem_wr) ? '0
                                            : len_width_p'(cnt_q) + len_width_p'(1);
        resp_hdr[SRC_LSB +: cord_width_p]   = my_cord_i;
        resp_hdr[OP_LSB]                    = op_q;
        resp_hdr[CNT_LSB +: count_width_p]  = cnt_q;
        resp_hdr[ADDR_LSB +: addr_width_p]  = addr_q;
    end

    bp_me_wormhole_mem_responder_if #(.flit_width_p(flit_width_p)) resp_if ();

    bp_me_wormhole_resp_tx #(.flit_width_p(flit_width_p)) u_resp_tx (
        .hdr_v_i  (hdr_v),
        .hdr_i    (resp_hdr),
        .data_v_i (data_v),
        .data_i   (data_q),
        .link     (resp_if),
        .yumi_o   (resp_yumi)
    );

    assign resp_if.ready_and = resp_link_i[flit_width_p];
    assign resp_link_o       = {resp_if.v, 1'b0, resp_if.data};
    assign cmd_link_o        = {1'b0, cmd_ready, {flit_width_p{1'b0}}};

    // Link bits this block never consumes (reverse-direction fields, dst/len).
    logic unused_bits;
    assign unused_bits = ^{cmd_link_i[flit_width_p], resp_link_i[flit_width_p+1],
                           resp_link_i[flit_width_p-1:0], cmd_flit};
endmodule

// File: tb/tb_bp_me_wormhole_mem_responder.sv
// Bench for bp_me_wormhole_mem_responder: table of packets plus hand-written
// reset sequences, with a queue-based scoreboard for memory requests and
// response flits.
module tb_bp_me_wormhole_mem_responder;
    import bp_me_wormhole_mem_responder_pkg::*;

    localparam int W  = 64;
    localparam int C  = 7;
    localparam int L  = 3;
    localparam int N  = 2;
    localparam int A  = 32;
    localparam int LW = W + 2;
    localparam logic [C-1:0] MY = 7'h2A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [C-1:0]  my_cord;
    logic          cmd_v;
    logic [W-1:0]  cmd_data;
    logic [LW-1:0] cmd_link_i, cmd_link_o, resp_link_o, resp_link_i;
    logic          resp_rdy     = 1'b1;
    logic          mem_v_o, mem_w_o;
    logic [A-1:0]  mem_addr_o;
    logic [W-1:0]  mem_data_o;
    logic          mem_ready_i  = 1'b1;
    logic          mem_data_v_i = 1'b0;
    logic [W-1:0]  mem_data_i   = '0;
    logic          cmd_rdy;

    assign cmd_link_i  = {cmd_v, 1'b0, cmd_data};
    assign resp_link_i = {1'b0, resp_rdy, {W{1'b0}}};
    assign cmd_rdy     = cmd_link_o[W];

    bp_me_wormhole_mem_responder_if #(.flit_width_p(W)) resp_mon ();
    assign resp_mon.v         = resp_link_o[W+1];
    assign resp_mon.data      = resp_link_o[W-1:0];
    assign resp_mon.ready_and = resp_rdy;

    bp_me_wormhole_mem_responder #(
        .flit_width_p(W), .cord_width_p(C), .len_width_p(L),
        .count_width_p(N), .addr_width_p(A)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .my_cord_i(my_cord),
        .cmd_link_i(cmd_link_i), .cmd_link_o(cmd_link_o),
        .resp_link_o(resp_link_o), .resp_link_i(resp_link_i),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
        .mem_data_v_i(mem_data_v_i), .mem_data_i(mem_data_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [A+W:0] exp_mem[$];   // {w, addr, data}
    logic [W-1:0] exp_resp[$];

    int resp_mode = 0;   // 0: always ready, 1: hold ready low 5 cycles per flit
    int mem_mode  = 0;   // 0: memory always ready, 1: ready toggles every cycle
    int stall_cnt = 0;
    bit rd_pending = 1'b0;
    logic [A-1:0] rd_addr = '0;
    bit prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_hdr(input logic [C-1:0] dst, input logic [L-1:0] len,
                                            input logic [C-1:0] src, input logic op,
                                            input logic [N-1:0] cnt, input logic [A-1:0] addr);
        return {12'b0, addr, cnt, op, src, len, dst};
    endfunction

    function automatic logic [W-1:0] memf(input logic [A-1:0] a);
        return {~a, a ^ 32'h5A5A_5A5A};
    endfunction

    function automatic logic [W-1:0] wdata(input logic [A-1:0] a);
        return {32'hD0D0_0000 | {16'h0, a[15:0]}, a};
    endfunction

    // Memory model and response-side ready pattern, updated just after each edge.
    always @(posedge clk) begin
        #1;
        mem_data_v_i = rd_pending;
        mem_data_i   = rd_pending ? memf(rd_addr) : '0;
        rd_pending   = 1'b0;
        mem_ready_i  = (mem_mode == 0) ? 1'b1 : ~mem_ready_i;
        resp_rdy     = (resp_mode == 0) || (stall_cnt >= 5);
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold  = 1'b0;
            stall_cnt  = 0;
            rd_pending = 1'b0;
        end else begin
            if (mem_v_o && mem_ready_i) begin
                if (exp_mem.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mem_unexpected: got w=%0b addr=%h, expected no request", mem_w_o, mem_addr_o);
                end else begin
                    check("mem_req", {mem_w_o, mem_addr_o, (mem_w_o ? mem_data_o : {W{1'b0}})},
                          exp_mem.pop_front());
                end
                if (!mem_w_o) begin
                    rd_pending = 1'b1;
                    rd_addr    = mem_addr_o;
                end
            end
            if (prev_hold) begin
                check("resp_hold_v", resp_mon.v, 1'b1);
                check("resp_hold_data", resp_mon.data, prev_data);
            end
            if (resp_mon.v && resp_mon.ready_and) begin
                if (exp_resp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got %h, expected no flit", resp_mon.data);
                end else begin
                    check("resp_flit", resp_mon.data, exp_resp.pop_front());
                end
                stall_cnt = 0;
            end else if (resp_mon.v) begin
                stall_cnt++;
            end
            prev_hold = resp_mon.v && !resp_mon.ready_and;
            prev_data = resp_mon.data;
        end
    end

    // Offer one command flit; returns just after the accepting edge.
    task automatic send_flit(input logic [W-1:0] d, input bit chk_mirror);
        bit ok;
        ok       = 1'b0;
        cmd_v    = 1'b1;
        cmd_data = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (chk_mirror) check("cmd_ready_mirror", cmd_rdy, mem_ready_i);
            if (cmd_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL cmd_accept_timeout: got no ready_and, expected accept of %h", d);
        end
        @(posedge clk);
        #1;
        cmd_v    = 1'b0;
        cmd_data = '0;
    endtask

    task automatic run_pkt(input bit wr, input int cnt, input logic [A-1:0] a,
                           input logic [C-1:0] src, input logic [L-1:0] exp_len);
        logic [A-1:0] ak;
        if (wr) begin
            for (int k = 0; k <= cnt; k++) begin
                ak = a + A'(k);
                exp_mem.push_back({1'b1, ak, wdata(ak)});
            end
            exp_resp.push_back(mk_hdr(src, exp_len, MY, 1'b1, N'(cnt), a));
        end else begin
            exp_resp.push_back(mk_hdr(src, exp_len, MY, 1'b0, N'(cnt), a));
            for (int k = 0; k <= cnt; k++) begin
                ak = a + A'(k);
                exp_mem.push_back({1'b0, ak, {W{1'b0}}});
                exp_resp.push_back(memf(ak));
            end
        end
        // Incoming len deliberately nonsense: the responder must use count.
        send_flit(mk_hdr(MY, 3'h7, src, wr, N'(cnt), a), 1'b0);
        if (wr) begin
            for (int k = 0; k <= cnt; k++) send_flit(wdata(a + A'(k)), mem_mode == 1);
        end
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_mem.size() == 0 && exp_resp.size() == 0) break;
        end
        check({nm, "_mem_left"}, exp_mem.size(), 0);
        check({nm, "_resp_left"}, exp_resp.size(), 0);
        exp_mem.delete();
        exp_resp.delete();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit           wr;
        int           cnt;
        logic [A-1:0] addr;
        logic [C-1:0] src;
        int           rmode;
        int           mmode;
        bit           drain_after;
        logic [L-1:0] exp_len;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 3, 32'h0000_0010, 7'h05, 0, 0, 1'b1, 3'd0};
        tbl[1] = '{1'b0, 1, 32'h0000_0020, 7'h09, 0, 0, 1'b1, 3'd2};
        tbl[2] = '{1'b0, 3, 32'h0000_0100, 7'h11, 1, 0, 1'b1, 3'd4};
        tbl[3] = '{1'b1, 3, 32'h0000_0030, 7'h12, 0, 1, 1'b1, 3'd0};
        tbl[4] = '{1'b0, 1, 32'hFFFF_FFFF, 7'h13, 0, 0, 1'b1, 3'd2};
        tbl[5] = '{1'b1, 0, 32'h0000_0055, 7'h21, 0, 0, 1'b0, 3'd0};
        tbl[6] = '{1'b0, 0, 32'h0000_0007, 7'h22, 0, 0, 1'b1, 3'd1};
        tbl[7] = '{1'b0, 2, 32'h0000_0200, 7'h7F, 1, 1, 1'b1, 3'd3};

        rst_n    = 1'b0;
        my_cord  = MY;
        cmd_v    = 1'b0;
        cmd_data = '0;
        #2;
        check("rst_cmd_ready", cmd_rdy, 1'b0);
        check("rst_resp_v", resp_mon.v, 1'b0);
        check("rst_mem_v", mem_v_o, 1'b0);
        check("rst_mem_bus", {mem_w_o, mem_addr_o, mem_data_o}, '0);

        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("release_ready_before_edge", cmd_rdy, 1'b0);
        @(posedge clk);
        #1;
        check("release_ready_after_edge", cmd_rdy, 1'b1);

        for (int i = 0; i < 8; i++) begin
            resp_mode = tbl[i].rmode;
            mem_mode  = tbl[i].mmode;
            run_pkt(tbl[i].wr, tbl[i].cnt, tbl[i].addr, tbl[i].src, tbl[i].exp_len);
            if (tbl[i].drain_after) drain($sformatf("pkt%0d", i));
        end
        resp_mode = 0;
        mem_mode  = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a write burst, with the third flit on the bus.
        exp_mem.push_back({1'b1, 32'h60, wdata(32'h60)});
        exp_mem.push_back({1'b1, 32'h61, wdata(32'h61)});
        send_flit(mk_hdr(MY, 3'h4, 7'h33, 1'b1, 2'd3, 32'h60), 1'b0);
        send_flit(wdata(32'h60), 1'b0);
        send_flit(wdata(32'h61), 1'b0);
        cmd_v    = 1'b1;
        cmd_data = wdata(32'h62);
        #2;
        check("midwr_mem_v_before_reset", mem_v_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midwr_rst_cmd_ready", cmd_rdy, 1'b0);
        check("midwr_rst_mem_v", mem_v_o, 1'b0);
        check("midwr_rst_mem_bus", {mem_w_o, mem_addr_o, mem_data_o}, '0);
        check("midwr_rst_resp_v", resp_mon.v, 1'b0);
        cmd_v    = 1'b0;
        cmd_data = '0;
        check("midwr_writes_seen", exp_mem.size(), 0);
        exp_mem.delete();
        exp_resp.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("midwr_release_ready_before_edge", cmd_rdy, 1'b0);
        @(posedge clk);
        #1;
        check("midwr_release_ready_after_edge", cmd_rdy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midwr_no_stale_ack", resp_mon.v, 1'b0);
        end
        @(posedge clk);
        #1;
        run_pkt(1'b0, 1, 32'h0000_0040, 7'h44, 3'd2);
        drain("post_reset_read");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bp_me_wormhole_mem_responder.md
BP_ME_WORMHOLE_MEM_RESPONDER -- requirements
Module: bp_me_wormhole_mem_responder

Interface
REQ-001 SHALL have parameter flit_width_p, default 64, link flit width and memory word width.
REQ-002 SHALL have parameter cord_width_p, default 7, router coordinate width.
REQ-003 SHALL have parameter len_width_p, default 3, wormhole length field width.
REQ-004 SHALL have parameter count_width_p, default 2, burst field width; value n means n+1 words.
REQ-005 SHALL have parameter addr_width_p, default 32, word address width.
REQ-006 SHALL have ports clk_i  in  1  clock; reset_n_i  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
REQ-007 SHALL have ports my_cord_i  in  cord_width_p  own coordinate, inserted as src in responses.
REQ-008 SHALL have ports cmd_link_i  in  bsg_ready_and_link_sif_width(flit_width_p)  {v, data} from network; cmd_link_o  out  same width  ready_and_rev to network.
REQ-009 SHALL have ports resp_link_o  out  same width  {v, data} to network; resp_link_i  in  same width  ready_and_rev from network.
REQ-010 SHALL have ports mem_v_o out 1, mem_w_o out 1, mem_addr_o out addr_width_p, mem_data_o out flit_width_p, mem_ready_i in 1  memory request valid/ready; mem_data_v_i in 1, mem_data_i in flit_width_p  in-order read return.

Function
REQ-011 Header flit layout, LSB first, SHALL be: dst cord, len, src cord, opcode (0 read, 1 write), count, addr; bits above SHALL be zero in generated headers.
REQ-012 Elaboration SHALL fail if 2*cord_width_p+len_width_p+1+count_width_p+addr_width_p > flit_width_p or 2^len_width_p-1 < 2^count_width_p.
REQ-013 FSM states SHALL be IDLE, WR_DATA, RD_REQ, RD_WAIT, RESP_HDR, RESP_DATA.
REQ-014 IDLE: cmd ready_and=1; on cmd v, latch header and go to WR_DATA if write else RESP_HDR.
REQ-015 WR_DATA: cmd ready_and = mem_ready_i; mem_v_o = cmd v, mem_w_o=1, mem_data_o = flit; each accepted flit writes addr+k; after count+1 flits go to RESP_HDR.
REQ-016 Write flit count SHALL come from the count field; the incoming len field is ignored.
REQ-017 RESP_HDR: resp v=1, dst=latched src, src=my_cord_i, opcode and count echoed, addr echoed, len = count+1 for read, 0 for write; on ready_and go to RD_REQ (read) or IDLE (write).
REQ-018 RD_REQ: mem_v_o=1, mem_w_o=0, mem_addr_o=addr+k; on mem_ready_i go to RD_WAIT.
REQ-019 RD_WAIT: on mem_data_v_i capture mem_data_i into a data register, go to RESP_DATA.
REQ-020 RESP_DATA: resp v=1 with data register; on ready_and increment k; if k was count go to IDLE else RD_REQ.
REQ-021 Address increment SHALL wrap modulo 2^addr_width_p.
REQ-022 cmd ready_and SHALL be 0 in every state except IDLE and WR_DATA; mem_v_o SHALL be 0 outside WR_DATA/RD_REQ.
REQ-023 resp v SHALL not drop or data change while ready_and is low (valid held until handshake).
REQ-024 Read latency minimum: header accept to response header valid 1 cycle; each data flit >= 2 cycles after its request.
REQ-025 Back-to-back packets: a new header SHALL be accepted in the cycle after returning to IDLE, no dead cycles beyond that.

Reset
REQ-026 reset_n_i low SHALL immediately force IDLE, k=0, all valids and ready_and outputs 0, mem outputs 0, regardless of packet in progress.
REQ-027 Partial packets interrupted by reset SHALL be discarded; no response is generated after reset release.
REQ-028 After reset release, cmd ready_and SHALL rise on the first clk_i edge.

Structure
REQ-029 Header struct, opcode enum and field-width macros SHALL live in bp_common_pkg / bp_me headers for reuse by the command sender.
REQ-030 Response serialization MAY use one sub-module, bp_me_wormhole_resp_tx (header/data mux with valid hold); all else flat.

Verification
REQ-031 Write count=3, addr 0x10, 4 flits D0..D3, mem_ready_i=1 -> writes 0x10..0x13 with D0..D3, then ack header len=0, dst=cmd src.
REQ-032 Read count=1, addr 0x20, mem returns A,B one cycle later -> header len=2 then flits A, B in order.
REQ-033 Read with resp ready_and low 5 cycles on each flit -> valid/data held stable, no duplicate or lost flit, no extra mem requests.
REQ-034 Write with mem_ready_i toggling 1/0 -> cmd ready_and mirrors it; exactly 4 writes issued.
REQ-035 Read addr 0xFFFFFFFF count=1 -> requests 0xFFFFFFFF then 0x0.
REQ-036 Assert reset_n_i mid-WR_DATA after 2 flits -> outputs 0 same cycle; post-release fresh read completes correctly, no stale ack.
